// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK  = 8'hF0;
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_RSHIFT = 8'h59;

    localparam logic [7:0] ASCII_ENTER = 8'h0D;
    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_CHECK = 2'd2
    } rx_state_t;

endpackage

// File: rtl/scan2ascii.sv
// Scan code set 2 to ASCII lookup; 0 means the code has no translation.
module scan2ascii
    import ps2_pkg::*;
(
    input  logic [7:0] code,
    input  logic       shift,
    output logic [7:0] ascii
);

    logic [7:0] base;

    // Lowercase/digit table
    always_comb begin
        base = 8'h00;
        case (code)
            8'h1C: base = 8'h61; 8'h32: base = 8'h62; 8'h21: base = 8'h63;
            8'h23: base = 8'h64; 8'h24: base = 8'h65; 8'h2B: base = 8'h66;
            8'h34: base = 8'h67; 8'h33: base = 8'h68; 8'h43: base = 8'h69;
            8'h3B: base = 8'h6A; 8'h42: base = 8'h6B; 8'h4B: base = 8'h6C;
            8'h3A: base = 8'h6D; 8'h31: base = 8'h6E; 8'h44: base = 8'h6F;
            8'h4D: base = 8'h70; 8'h15: base = 8'h71; 8'h2D: base = 8'h72;
            8'h1B: base = 8'h73; 8'h2C: base = 8'h74; 8'h3C: base = 8'h75;
            8'h2A: base = 8'h76; 8'h1D: base = 8'h77; 8'h22: base = 8'h78;
            8'h35: base = 8'h79; 8'h1A: base = 8'h7A;
            8'h45: base = 8'h30; 8'h16: base = 8'h31; 8'h1E: base = 8'h32;
            8'h26: base = 8'h33; 8'h25: base = 8'h34; 8'h2E: base = 8'h35;
            8'h36: base = 8'h36; 8'h3D: base = 8'h37; 8'h3E: base = 8'h38;
            8'h46: base = 8'h39;
            8'h29: base = ASCII_SPACE;
            8'h5A: base = ASCII_ENTER;
            8'h66: base = ASCII_BS;
            default: base = 8'h00;
        endcase
    end

    // Shift only affects letters
    always_comb begin
        ascii = base;
        if (shift && (base >= 8'h61) && (base <= 8'h7A)) begin
            ascii = base - 8'h20;
        end
    end

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: frame capture, make/break decode, ASCII keystroke FIFO.
// Optional PS2_SHIFT_EN: track shift keys and emit uppercase letters.
module ps2_key_receiver
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] ascii,
    output logic       valid,
    input  logic       ready,
    output logic [7:0] scan_code,
    output logic       overflow,
    output logic       frame_err
);

    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [2:0]      clk_sync;
    logic [2:0]      dat_sync;
    logic            fall;
    logic            bit_in;

    rx_state_t       state;
    rx_state_t       state_next;
    logic [3:0]      bitcnt;
    logic [9:0]      shreg;
    logic [WD_W-1:0] wd_cnt;
    logic            wd_hit;

    logic            shift_en;
    logic            frame_done;
    logic            timeout;
    logic            start_err;
    logic            frame_ok;
    logic [7:0]      code;

    logic [7:0]      held_key;
    logic [7:0]      held_key_next;
    logic            brk_pend;
    logic            brk_pend_next;
    logic            ext_pend;
    logic            ext_pend_next;
    logic            shift_held;
    logic [7:0]      xlat;
    logic            push;

`ifdef PS2_SHIFT_EN
    logic            shift_l;
    logic            shift_l_next;
    logic            shift_r;
    logic            shift_r_next;
`endif

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic            empty;
    logic            full;
    logic            pop;
    logic            wr_en;

    // Input synchronisers
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync <= 3'b000;
            dat_sync <= 3'b000;
        end else begin
            clk_sync <= {clk_sync[1:0], ps2_clk};
            dat_sync <= {dat_sync[1:0], ps2_data};
        end
    end

    assign fall   = (clk_sync[2:1] == 2'b10);
    assign bit_in = dat_sync[1];
    assign wd_hit = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    // Receive FSM: state register
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Receive FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (fall && !bit_in) state_next = ST_RECV;
            end
            ST_RECV: begin
                if (fall && (bitcnt == 4'd9)) state_next = ST_CHECK;
                else if (!fall && wd_hit)     state_next = ST_IDLE;
            end
            ST_CHECK: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Receive FSM: control outputs
    always_comb begin
        shift_en   = 1'b0;
        frame_done = 1'b0;
        timeout    = 1'b0;
        start_err  = 1'b0;
        case (state)
            ST_IDLE: start_err = fall && bit_in;
            ST_RECV: begin
                shift_en = fall;
                timeout  = !fall && wd_hit;
            end
            ST_CHECK: frame_done = 1'b1;
            default: ;
        endcase
    end

    // Shift register, bit counter and inter-edge watchdog
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            bitcnt <= 4'd0;
            shreg  <= 10'd0;
            wd_cnt <= '0;
        end else begin
            if (state == ST_IDLE) begin
                bitcnt <= 4'd0;
            end else if (shift_en) begin
                bitcnt <= bitcnt + 4'd1;
            end
            if (shift_en) begin
                shreg <= {bit_in, shreg[9:1]};
            end
            if ((state != ST_RECV) || fall) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
        end
    end

    assign code     = shreg[7:0];
    assign frame_ok = frame_done && (^shreg[8:0]) && shreg[9];

    // Registered status outputs
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            scan_code <= 8'h00;
            frame_err <= 1'b0;
        end else begin
            frame_err <= (frame_done && !frame_ok) || timeout || start_err;
            if (frame_ok) begin
                scan_code <= code;
            end
        end
    end

`ifdef PS2_SHIFT_EN
    assign shift_held = shift_l || shift_r;
`else
    assign shift_held = 1'b0;
`endif

    scan2ascii u_scan2ascii (
        .code  (code),
        .shift (shift_held),
        .ascii (xlat)
    );

    // Make/break decoder, acting on the byte presented during CHECK
    always_comb begin
        held_key_next = held_key;
        brk_pend_next = brk_pend;
        ext_pend_next = ext_pend;
        push          = 1'b0;
`ifdef PS2_SHIFT_EN
        shift_l_next  = shift_l;
        shift_r_next  = shift_r;
`endif
        if (frame_ok) begin
            if (code == PS2_BREAK) begin
                brk_pend_next = 1'b1;
            end else if (code == PS2_EXT) begin
                ext_pend_next = 1'b1;
            end else if (brk_pend) begin
                if (code == held_key) held_key_next = 8'h00;
`ifdef PS2_SHIFT_EN
                if (code == PS2_LSHIFT) shift_l_next = 1'b0;
                if (code == PS2_RSHIFT) shift_r_next = 1'b0;
`endif
                brk_pend_next = 1'b0;
                ext_pend_next = 1'b0;
            end else if (ext_pend) begin
                ext_pend_next = 1'b0;
`ifdef PS2_SHIFT_EN
            end else if (code == PS2_LSHIFT) begin
                shift_l_next = 1'b1;
            end else if (code == PS2_RSHIFT) begin
                shift_r_next = 1'b1;
`endif
            end else if (code != held_key) begin
                held_key_next = code;
                push          = (xlat != 8'h00);
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            held_key <= 8'h00;
            brk_pend <= 1'b0;
            ext_pend <= 1'b0;
`ifdef PS2_SHIFT_EN
            shift_l  <= 1'b0;
            shift_r  <= 1'b0;
`endif
        end else begin
            held_key <= held_key_next;
            brk_pend <= brk_pend_next;
            ext_pend <= ext_pend_next;
`ifdef PS2_SHIFT_EN
            shift_l  <= shift_l_next;
            shift_r  <= shift_r_next;
`endif
        end
    end

    // Keystroke FIFO; extra pointer bit distinguishes full from empty
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign valid = !empty;
    assign pop   = valid && ready;
    assign wr_en = push && (!full || pop);
    assign ascii = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= xlat;
        end
    end

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Scoreboard bench for ps2_key_receiver: directed PS/2 frames, monitor checks FIFO output.
module tb_ps2_key_receiver;

    localparam int unsigned TO_CYC = 3000;

    logic       clk;
    logic       clrn;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] ascii;
    logic       valid;
    logic       ready;
    logic [7:0] scan_code;
    logic       overflow;
    logic       frame_err;

    int         checks;
    int         errors;
    int         err_cnt;
    logic [7:0] exp_q[$];

    ps2_key_receiver #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ascii     (ascii),
        .valid     (valid),
        .ready     (ready),
        .scan_code (scan_code),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: pop expected entries when the consumer accepts, count error pulses
    always @(negedge clk) begin
        if (clrn) begin
            if (valid && ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pop actual=%0h required=none", ascii);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (ascii !== e) begin
                        errors++;
                        $display("FAIL pop_ascii actual=%0h required=%0h", ascii, e);
                    end
                end
            end
            if (frame_err) err_cnt++;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            wait_clk(10);
            ps2_clk = 1'b0;
            wait_clk(20);
            ps2_clk = 1'b1;
            wait_clk(10);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par);
        logic [10:0] f;
        logic        p;
        p = ~(^b) ^ bad_par;
        f = {1'b1, p, b, 1'b0};
        send_bits(f, 11);
        ps2_data = 1'b1;
        wait_clk(40);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            wait_clk(1);
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout actual=hung required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] keys [9];
        logic [7:0] p_frame;
        checks   = 0;
        errors   = 0;
        err_cnt  = 0;
        clrn     = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        ready    = 1'b1;
        wait_clk(5);
        @(negedge clk);
        check("rst_valid",     32'(valid),     32'd0);
        check("rst_ascii",     32'(ascii),     32'h00);
        check("rst_scan_code", 32'(scan_code), 32'h00);
        check("rst_overflow",  32'(overflow),  32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        wait_clk(1);
        clrn = 1'b1;
        wait_clk(10);

        // Single key 'a', then release
        exp_q.push_back(8'h61);
        send_byte(8'h1C, 1'b0);
        check("t1_scan_code", 32'(scan_code), 32'h1C);
        wait_drain("t1_drained");
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);
        check("t1_valid_low", 32'(valid), 32'd0);

        // Typematic repeats suppressed, post-break make accepted
        exp_q.push_back(8'h61);
        exp_q.push_back(8'h61);
        send_byte(8'h1C, 1'b0);
        send_byte(8'h1C, 1'b0);
        send_byte(8'h1C, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);
        send_byte(8'h1C, 1'b0);
        wait_drain("t2_drained");
        check("t2_err_cnt", 32'(err_cnt), 32'd0);

        // Parity error
        send_byte(8'h16, 1'b1);
        check("t3_err_cnt",   32'(err_cnt),   32'd1);
        check("t3_scan_code", 32'(scan_code), 32'h1C);
        check("t3_valid",     32'(valid),     32'd0);

        // Mid-frame timeout, then a good frame '0'
        p_frame = 8'h45;
        send_bits({1'b1, 1'b0, p_frame, 1'b0}, 5);
        ps2_data = 1'b1;
        wait_clk(TO_CYC + 100);
        check("t4_timeout_err", 32'(err_cnt), 32'd2);
        exp_q.push_back(8'h30);
        send_byte(8'h45, 1'b0);
        wait_drain("t4_drained");
        check("t4_scan_code", 32'(scan_code), 32'h45);
        check("t4_overflow",  32'(overflow),  32'd0);

        // Overflow: nine keys with consumer stalled
        keys = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
        ready = 1'b0;
        for (int i = 0; i < 8; i++) exp_q.push_back(8'h61 + 8'(i));
        for (int i = 0; i < 9; i++) begin
            send_byte(keys[i], 1'b0);
            send_byte(8'hF0, 1'b0);
            send_byte(keys[i], 1'b0);
        end
        check("t5_overflow", 32'(overflow), 32'd1);
        check("t5_valid",    32'(valid),    32'd1);
        check("t5_head",     32'(ascii),    32'h61);
        ready = 1'b1;
        wait_drain("t5_drained");
        wait_clk(5);
        check("t5_empty_after", 32'(valid), 32'd0);

        // Shift handling
`ifdef PS2_SHIFT_EN
        exp_q.push_back(8'h41);
`else
        exp_q.push_back(8'h61);
`endif
        exp_q.push_back(8'h61);
        send_byte(8'h12, 1'b0);
        send_byte(8'h1C, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h1C, 1'b0);
        wait_drain("t6_drained");
        check("t6_err_cnt", 32'(err_cnt), 32'd2);

        wait_clk(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
